// File: rtl/sqrt_seq_ctrl_pkg.sv
// Shared types and defaults for the square-root sequencing controller.
// The state encoding is 3-bit binary so the datapath and bench can decode it.
package sqrt_seq_ctrl_pkg;

    localparam int SQRT_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_INIT   = 3'd2,
        ST_CMP    = 3'd3,
        ST_ADD_SQ = 3'd4,
        ST_ADD_D  = 3'd5,
        ST_FINISH = 3'd6,
        ST_DONE   = 3'd7
    } sqrt_state_e;

    // The loop runs at most sqrt(2**data_w) times for any radicand of that width.
    function automatic int sqrt_max_iter(input int data_w);
        return 2 ** (data_w / 2);
    endfunction

endpackage

// File: rtl/sqrt_seq_ctrl_if.sv
// Handshake and strobe bundle between the request side / register datapath
// (master) and the sequencing controller (slave).
interface sqrt_seq_ctrl_if #(
    parameter int ITER_W = 5
);
    logic              start;
    logic              abort;
    logic              le_flag;
    logic              x_en;
    logic              regs_clear;
    logic              adder_sel;
    logic              square_en;
    logic              delta_en;
    logic              result_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter_count;

    modport master (
        output start, abort, le_flag,
        input  x_en, regs_clear, adder_sel, square_en, delta_en, result_en,
        input  busy, done, err, iter_count
    );

    modport slave (
        input  start, abort, le_flag,
        output x_en, regs_clear, adder_sel, square_en, delta_en, result_en,
        output busy, done, err, iter_count
    );

endinterface

// File: rtl/sqrt_seq_ctrl_iter_cnt.sv
// Saturating iteration counter: clear has priority, increments stop at MAX_ITER.
module sqrt_seq_ctrl_iter_cnt #(
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ITER_W-1:0] count,
    output logic              at_max
);

    logic [ITER_W-1:0] cnt_q;

    // Count completed iterations; holding at the limit keeps the watchdog sticky.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_max = (cnt_q == ITER_W'(MAX_ITER));
    assign count  = cnt_q;

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// Sequencer for the iterative integer square root:
//   sq=1, d=3; while (sq <= x) { sq += d; d += 2; } root = (d>>1)-1
// Issues one register strobe per state and watches for a runaway loop.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | capture radicand (x_en)
// INIT   | preset sq=1, d=3 (regs_clear)
// CMP    | evaluate le_flag, loop or finish
// ADD_SQ | sq <= sq + d (adder_sel=0, square_en)
// ADD_D  | d <= d + 2 (adder_sel=1, delta_en), one iteration done
// FINISH | capture root (result_en)
// DONE   | one-cycle done pulse
module sqrt_seq_ctrl
    import sqrt_seq_ctrl_pkg::*;
#(
    parameter int DATA_W   = SQRT_DATA_W,
    parameter int MAX_ITER = sqrt_max_iter(DATA_W),
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input logic           clock,
    input logic           reset,
    sqrt_seq_ctrl_if.slave bus
);

    sqrt_state_e       state_q;
    sqrt_state_e       state_nxt;
    logic              err_q;
    logic              cnt_clear;
    logic              cnt_inc;
    logic              at_max;
    logic [ITER_W-1:0] cnt_val;

    sqrt_seq_ctrl_iter_cnt #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) u_iter_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .count  (cnt_val),
        .at_max (at_max)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Watchdog flag: set when the loop would exceed MAX_ITER, kept until the next start.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.start) begin
            err_q <= 1'b0;
        end else if (state_q == ST_CMP && !bus.abort && bus.le_flag && at_max) begin
            err_q <= 1'b1;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt      = state_q;
        bus.x_en       = 1'b0;
        bus.regs_clear = 1'b0;
        bus.adder_sel  = 1'b0;
        bus.square_en  = 1'b0;
        bus.delta_en   = 1'b0;
        bus.result_en  = 1'b0;
        bus.done       = 1'b0;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus.x_en  = 1'b1;
                state_nxt = bus.abort ? ST_IDLE : ST_INIT;
            end
            ST_INIT: begin
                bus.regs_clear = 1'b1;
                state_nxt      = bus.abort ? ST_IDLE : ST_CMP;
            end
            ST_CMP: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (bus.le_flag) begin
                    state_nxt = at_max ? ST_DONE : ST_ADD_SQ;
                end else begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_ADD_SQ: begin
                bus.adder_sel = 1'b0;
                bus.square_en = 1'b1;
                state_nxt     = bus.abort ? ST_IDLE : ST_ADD_D;
            end
            ST_ADD_D: begin
                bus.adder_sel = 1'b1;
                bus.delta_en  = 1'b1;
                cnt_inc       = !bus.abort;
                state_nxt     = bus.abort ? ST_IDLE : ST_CMP;
            end
            ST_FINISH: begin
                // An abort landing here must not publish a result.
                bus.result_en = !bus.abort;
                state_nxt     = bus.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.err        = err_q;
    assign bus.iter_count = cnt_val;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Bench for sqrt_seq_ctrl: a behavioural square/delta datapath answers the
// controller's strobes, and results are compared with floor(sqrt(x)).
module tb_sqrt_seq_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    sqrt_seq_ctrl_if #(.ITER_W(5)) bus ();

    sqrt_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int x_drv    = 0;
    bit force_le = 1'b0;
    int x_reg = 0, sq = 1, d = 3, root = 0;
    int res_cnt = 0, done_cnt = 0, ovl_cnt = 0;

    // Behavioural register datapath driven by the controller's strobes.
    always @(posedge clock) begin
        if (bus.x_en)       x_reg <= x_drv;
        if (bus.regs_clear) begin sq <= 1; d <= 3; end
        if (bus.square_en)  sq <= sq + d;
        if (bus.delta_en)   d <= d + 2;
        if (bus.result_en)  root <= (d >> 1) - 1;
    end

    always_comb bus.le_flag = force_le || (sq <= x_reg);

    // Pulse counters and register-enable overlap detector.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.result_en === 1'b1) res_cnt <= res_cnt + 1;
            if (bus.done === 1'b1)      done_cnt <= done_cnt + 1;
            if (int'(bus.x_en) + int'(bus.square_en) + int'(bus.delta_en) + int'(bus.result_en) > 1)
                ovl_cnt <= ovl_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic int isqrt(input int x);
        int n = 0;
        for (int k = 0; k <= 16; k++) if (k * k <= x) n = k;
        return n;
    endfunction

    // Starts one operation from an idle negedge and returns the cycle on which done is seen.
    task automatic run_op(input int x, input bit hold, input bit pulse, output int cyc);
        x_drv = x;
        bus.start = 1'b1;
        @(posedge clock); #1;
        if (!hold) bus.start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (bus.done === 1'b1) break;
            if (pulse) bus.start = 1'($urandom_range(0, 1));
        end
        if (pulse) bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL op_timeout x=%0d no done after %0d cycles", x, cyc);
        end
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({bus.x_en, bus.regs_clear, bus.adder_sel, bus.square_en, bus.delta_en,
             bus.result_en, bus.busy, bus.done, bus.err} !== 9'b0 || bus.iter_count !== 5'd0) begin
            n_err++;
            $display("FAIL reset_por outs=%b iter=%0d required all zero",
                     {bus.x_en, bus.regs_clear, bus.adder_sel, bus.square_en, bus.delta_en,
                      bus.result_en, bus.busy, bus.done, bus.err}, bus.iter_count);
        end
        reset = 1'b0;
        @(negedge clock);
        x_drv = 200;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clock);
            if (bus.square_en === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 2 || bus.iter_count !== 5'd1) begin
            n_err++;
            $display("FAIL reset_reach_add_sq seen=%0d iter=%0d required 2 and 1", seen, bus.iter_count);
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({bus.x_en, bus.regs_clear, bus.adder_sel, bus.square_en, bus.delta_en,
             bus.result_en, bus.busy, bus.done, bus.err} !== 9'b0 || bus.iter_count !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid_op outs=%b iter=%0d required all zero",
                     {bus.x_en, bus.regs_clear, bus.adder_sel, bus.square_en, bus.delta_en,
                      bus.result_en, bus.busy, bus.done, bus.err}, bus.iter_count);
        end
    endtask

    task automatic test_fixed(input int x);
        int cyc, r0, n;
        n = isqrt(x);
        r0 = res_cnt;
        run_op(x, 1'b0, 1'b0, cyc);
        @(negedge clock);
        n_cmp++;
        if (cyc != 5 + 3 * n || int'(bus.iter_count) != n || bus.err !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_x%0d cyc=%0d iter=%0d err=%b required cyc=%0d iter=%0d err=0",
                     x, cyc, bus.iter_count, bus.err, 5 + 3 * n, n);
        end
        n_cmp++;
        if (root != n || res_cnt - r0 != 1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_x%0d_result root=%0d res_pulses=%0d done=%b required root=%0d pulses=1 done=0",
                     x, root, res_cnt - r0, bus.done, n);
        end
    endtask

    task automatic test_random();
        int x, cyc, n;
        for (int i = 0; i < 8; i++) begin
            x = int'($urandom_range(0, 255));
            n = isqrt(x);
            run_op(x, 1'b0, 1'b0, cyc);
            @(negedge clock);
            n_cmp++;
            if (cyc != 5 + 3 * n || int'(bus.iter_count) != n || root != n || bus.err !== 1'b0) begin
                n_err++;
                $display("FAIL random_x%0d cyc=%0d iter=%0d root=%0d err=%b required cyc=%0d iter=%0d root=%0d err=0",
                         x, cyc, bus.iter_count, root, bus.err, 5 + 3 * n, n, n);
            end
        end
    endtask

    task automatic test_watchdog();
        int cyc, r0;
        r0 = res_cnt;
        force_le = 1'b1;
        run_op(100, 1'b0, 1'b0, cyc);
        n_cmp++;
        if (cyc != 52 || bus.err !== 1'b1 || bus.iter_count !== 5'd16) begin
            n_err++;
            $display("FAIL watchdog cyc=%0d err=%b iter=%0d required cyc=52 err=1 iter=16",
                     cyc, bus.err, bus.iter_count);
        end
        force_le = 1'b0;
        repeat (4) @(negedge clock);
        n_cmp++;
        if (bus.err !== 1'b1 || bus.iter_count !== 5'd16 || res_cnt != r0) begin
            n_err++;
            $display("FAIL watchdog_hold err=%b iter=%0d res_pulses=%0d required err=1 iter=16 pulses=0",
                     bus.err, bus.iter_count, res_cnt - r0);
        end
        x_drv = 9;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.err !== 1'b0 || bus.iter_count !== 5'd0 || bus.x_en !== 1'b1) begin
            n_err++;
            $display("FAIL watchdog_clear err=%b iter=%0d x_en=%b required 0 0 1",
                     bus.err, bus.iter_count, bus.x_en);
        end
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) @(negedge clock);
    endtask

    task automatic test_abort();
        int seen, dc0, r0, cyc;
        x_drv = 200;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clock);
            if (bus.delta_en === 1'b1) seen++;
        end
        bus.abort = 1'b1;
        @(posedge clock); #1;
        bus.abort = 1'b0;
        @(negedge clock);
        dc0 = done_cnt;
        r0 = res_cnt;
        n_cmp++;
        if (seen != 2 || bus.busy !== 1'b0 || bus.iter_count !== 5'd1) begin
            n_err++;
            $display("FAIL abort seen=%0d busy=%b iter=%0d required seen=2 busy=0 iter=1",
                     seen, bus.busy, bus.iter_count);
        end
        repeat (10) @(negedge clock);
        n_cmp++;
        if (done_cnt != dc0 || res_cnt != r0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_quiet done_pulses=%0d res_pulses=%0d busy=%b required 0 0 0",
                     done_cnt - dc0, res_cnt - r0, bus.busy);
        end
        run_op(16, 1'b0, 1'b0, cyc);
        @(negedge clock);
        n_cmp++;
        if (cyc != 17 || bus.iter_count !== 5'd4 || root != 4) begin
            n_err++;
            $display("FAIL abort_restart cyc=%0d iter=%0d root=%0d required 17 4 4",
                     cyc, bus.iter_count, root);
        end
    endtask

    task automatic test_back_to_back();
        int x, n, cyc, dc0;
        dc0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            x = int'($urandom_range(0, 255));
            n = isqrt(x);
            run_op(x, 1'b0, 1'b1, cyc);
            @(negedge clock);
            n_cmp++;
            if (cyc != 5 + 3 * n || root != n || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL pulse_ignore x=%0d cyc=%0d root=%0d done=%b required cyc=%0d root=%0d done=0",
                         x, cyc, root, bus.done, 5 + 3 * n, n);
            end
        end
        n_cmp++;
        if (done_cnt - dc0 != 3) begin
            n_err++;
            $display("FAIL pulse_done_count got=%0d required 3", done_cnt - dc0);
        end
        dc0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            x = int'($urandom_range(0, 255));
            n = isqrt(x);
            run_op(x, 1'b1, 1'b0, cyc);
            @(negedge clock);
            n_cmp++;
            if (cyc != 5 + 3 * n || root != n || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL held_start x=%0d cyc=%0d root=%0d done=%b busy=%b required cyc=%0d root=%0d done=0 busy=0",
                         x, cyc, root, bus.done, bus.busy, 5 + 3 * n, n);
            end
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (done_cnt - dc0 != 3 || ovl_cnt != 0) begin
            n_err++;
            $display("FAIL held_done_count got=%0d overlaps=%0d required 3 and 0",
                     done_cnt - dc0, ovl_cnt);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_fixed(0);
        test_fixed(255);
        test_random();
        test_watchdog();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
